// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: state encodings and parity helper shared by the serial pattern generator
package moore_seq_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  function automatic logic even_par(input logic [31:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/seq_bit_ctr.sv
// seq_bit_ctr: down-counter with load, decrement and zero flag; ports clk, rst (active-low sync), load, dec, ld_val -> cnt, zero
module seq_bit_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  // load wins over decrement; decrement saturates at zero so the count never wraps
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else if (load) cnt <= ld_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/moore_seq_gen.sv
// moore_seq_gen: Moore serial pattern generator, MSB-first, (rep_in+1) back-to-back repetitions then a done pulse
// ports: clk, rst (active-low sync), start, pat_in, rep_in -> out, out_valid, busy, frame_sof, done
// SEQ_GEN_PARITY_EN: when defined, an even-parity bit follows every repetition
module moore_seq_gen
  import moore_seq_pkg::*;
#(
  parameter int   PAT_W    = 3,
  parameter int   REP_W    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [REP_W-1:0] rep_in,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_sof,
  output logic             done
);
  localparam int BW = $clog2(PAT_W);
  logic [1:0] state, nxt;
  logic [PAT_W-1:0] shreg, pat_reg;
  logic [BW-1:0] bit_cnt;
  logic [REP_W-1:0] unused_rep_cnt;
  logic bit_zero, rep_zero, accept, rep_end, reload;
  assign accept = state == ST_IDLE && start;
`ifdef SEQ_GEN_PARITY_EN
  assign rep_end = state == ST_PAR;
  assign nxt = accept ? ST_SHIFT :
               state == ST_DONE ? ST_IDLE :
               rep_end ? (rep_zero ? ST_DONE : ST_SHIFT) :
               (state == ST_SHIFT && bit_zero) ? ST_PAR : state;
  assign out = state == ST_SHIFT ? shreg[PAT_W-1] :
               state == ST_PAR ? even_par(32'(pat_reg)) : IDLE_LVL;
`else
  assign rep_end = state == ST_SHIFT && bit_zero;
  assign nxt = accept ? ST_SHIFT :
               state == ST_DONE ? ST_IDLE :
               rep_end ? (rep_zero ? ST_DONE : ST_SHIFT) : state;
  assign out = state == ST_SHIFT ? shreg[PAT_W-1] : IDLE_LVL;
`endif
  // another repetition follows directly, with no idle gap
  assign reload    = rep_end && !rep_zero;
  assign out_valid = state == ST_SHIFT || state == ST_PAR;
  assign busy      = state != ST_IDLE;
  assign done      = state == ST_DONE;
  assign frame_sof = state == ST_SHIFT && bit_cnt == BW'(PAT_W - 1);
  seq_bit_ctr #(.W(BW)) u_bit (
    .clk(clk), .rst(rst), .load(accept || reload), .dec(state == ST_SHIFT),
    .ld_val(BW'(PAT_W - 1)), .cnt(bit_cnt), .zero(bit_zero)
  );
  seq_bit_ctr #(.W(REP_W)) u_rep (
    .clk(clk), .rst(rst), .load(accept), .dec(reload),
    .ld_val(rep_in), .cnt(unused_rep_cnt), .zero(rep_zero)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      pat_reg <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        shreg   <= pat_in;
        pat_reg <= pat_in;
      end else if (reload) shreg <= pat_reg;
      else if (state == ST_SHIFT && !bit_zero) shreg <= shreg << 1;
    end
endmodule

// File: tb/tb_moore_seq_gen.sv
// tb_moore_seq_gen: randomized scoreboard bench for moore_seq_gen against a per-cycle expected-output model
module tb_moore_seq_gen;
  localparam int   PW = 3;
  localparam int   RW = 4;
  localparam logic IL = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b1;
  logic [PW-1:0] pat_in = '1;
  logic [RW-1:0] rep_in = '1;
  logic out, out_valid, busy, frame_sof, done;
  typedef struct {int c; logic [4:0] v;} item_t;
  item_t q[$];
  int cyc = 0, checks = 0, failures = 0;
  logic [4:0] exp_v, act_v;

  moore_seq_gen #(.PAT_W(PW), .REP_W(RW), .IDLE_LVL(IL)) dut (
    .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .rep_in(rep_in),
    .out(out), .out_valid(out_valid), .busy(busy), .frame_sof(frame_sof), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expected outputs per cycle: each entry is {out, out_valid, frame_sof, done, busy}
  task automatic push_frame(input logic [PW-1:0] p, input logic [RW-1:0] r, output int len);
    int a;
    a = cyc + 1;
    len = (int'(r) + 1) * (PW + PAR);
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = PW - 1; i >= 0; i--) begin
        q.push_back('{a, {p[i], 1'b1, (i == PW - 1), 1'b0, 1'b1}});
        a++;
      end
      if (PAR != 0) begin
        q.push_back('{a, {^p, 1'b1, 1'b0, 1'b0, 1'b1}});
        a++;
      end
    end
    q.push_back('{a, {IL, 1'b0, 1'b0, 1'b1, 1'b1}});
  endtask

  task automatic frame(input logic [PW-1:0] p, input logic [RW-1:0] r, input bit hold);
    int len;
    @(negedge clk);
    start = 1'b1; pat_in = p; rep_in = r;
    push_frame(p, r, len);
    repeat (len + 1) begin
      @(negedge clk);
      start  = hold ? 1'b1 : 1'($urandom);
      pat_in = hold ? 3'b010 : PW'($urandom);
      rep_in = RW'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      pat_in = PW'($urandom);
    end
  endtask

  always @(negedge clk)
    if (cyc >= 1) begin
      exp_v = {IL, 4'b0000};
      if (q.size() > 0 && q[0].c == cyc) begin
        exp_v = q[0].v;
        void'(q.pop_front());
      end
      act_v = {out, out_valid, frame_sof, done, busy};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL outputs cyc=%0d {out,valid,sof,done,busy} got=%b expected=%b", cyc, act_v, exp_v);
      end
    end

  initial begin
    int len;
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    frame(3'b101, 4'd0, 1'b0);
    idle(2);
    frame(3'b101, 4'd2, 1'b1);
    frame(3'b010, 4'd0, 1'b0);
    idle(2);
    @(negedge clk);
    start = 1'b1; pat_in = 3'b101; rep_in = 4'd0;
    push_frame(3'b101, 4'd0, len);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    while (q.size() > 0 && q[$].c > cyc) void'(q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    frame(3'b111, 4'd15, 1'b0);
    frame(3'b000, 4'd0, 1'b0);
    frame(3'b110, 4'd1, 1'b1);
    repeat (25) begin
      frame(PW'($urandom), RW'($urandom_range(0, 5)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(5);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
